// File: rtl/johnson_seq_ctrl.sv
// Johnson (twisted ring) step sequencer.
// A start command runs the ring a given number of steps. Each step is separated by a
// programmable number of clocks. Normal completion raises done for one cycle. The ring can
// also be seeded with a valid Johnson code while the block is idle.
module johnson_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] div,
  input  logic             abort,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ring_q, ring_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] ring_fwd, ring_rev;
  logic [WIDTH-2:0] load_diff;
  logic             load_ok;

  // Ring successors, and the seed check: a reachable Johnson state is a run of ones
  // anchored at one end, i.e. at most one change between neighbouring bits.
  always_comb begin
    ring_fwd  = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
    ring_rev  = {~ring_q[0], ring_q[WIDTH-1:1]};
    load_diff = load_val[WIDTH-1:1] ^ load_val[WIDTH-2:0];
    load_ok   = $onehot0(load_diff);
  end

  // Next-state logic for the sequencer FSM and its datapath.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    div_d   = div_q;
    dir_d   = dir_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Load has priority; a start presented together with it is dropped.
        if (load) begin
          if (load_ok) begin
            ring_d = load_val;
          end else begin
            err_d = 1'b1;
          end
        end else if (start) begin
          if (steps != '0) begin
            dir_d   = dir;
            div_d   = div;
            cnt_d   = steps;
            pre_d   = div;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        // Abort beats a step that falls due in the same cycle.
        if (abort) begin
          state_d = StIdle;
        end else if (pre_q != '0) begin
          pre_d = pre_q - 1'b1;
        end else begin
          ring_d = dir_q ? ring_fwd : ring_rev;
          cnt_d  = cnt_q - 1'b1;
          pre_d  = div_q;
          if (cnt_q == CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      ring_q  <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      div_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign q        = ring_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Scoreboard bench for johnson_seq_ctrl: stimulus tasks push expected events, and a
// negedge monitor pops and compares them whenever q changes or done/err pulse.
module tb_johnson_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 8;
  localparam int DW = 8;
  localparam int NS = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [CW-1:0] steps = '0;
  logic [DW-1:0] div = '0;
  logic          abort = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  q;
  logic          busy, done, err;
  logic [CW-1:0] step_cnt;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .steps(steps), .div(div),
    .abort(abort), .load(load), .load_val(load_val), .q(q), .busy(busy), .done(done),
    .err(err), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // Edge counter and reset level seen at each edge.
  int   cyc = 0;
  logic rst_s = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // kind: 0 = q change, 1 = done pulse, 2 = err pulse
  typedef struct {
    int           kind;
    logic [W-1:0] qv;
    int           cnt;
    int           at;
  } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int m_idx   = 0;  // model ring position, 0 = all zeros
  int m_cnt   = 0;  // model step_cnt

  // Ring position k: forward from zero shifts ones in at bit 0, then zeros.
  function automatic logic [W-1:0] jc(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i] = (k > i) && (k <= i + W);
    return v;
  endfunction

  function automatic int idx_of(input logic [W-1:0] v);
    for (int k = 0; k < NS; k++) if (jc(k) == v) return k;
    return -1;
  endfunction

  function automatic int step_idx(input int i, input bit d);
    return d ? (i + 1) % NS : (i + NS - 1) % NS;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon_event(input int kind);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d q=%b cnt=%0d cyc=%0d, expected none",
               kind, q, step_cnt, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.qv !== q || e.cnt != int'(step_cnt) || e.at != cyc ||
          (kind == 1 && busy !== 1'b0)) begin
        n_fail++;
        $display("FAIL event: got kind=%0d q=%b cnt=%0d cyc=%0d busy=%b, expected kind=%0d q=%b cnt=%0d cyc=%0d",
                 kind, q, step_cnt, cyc, busy, e.kind, e.qv, e.cnt, e.at);
      end
    end
  endtask

  // Monitor: outputs are stable at the falling edge.
  logic [W-1:0] prev_q;
  always @(negedge clk) begin
    if (rst_s === 1'b1) begin
      if (q !== prev_q) mon_event(0);
      if (done === 1'b1) mon_event(1);
      if (err === 1'b1) mon_event(2);
    end
    prev_q = q;
  end

  task automatic end_checks(input string tag);
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_q"}, int'(q), int'(jc(m_idx)));
    check({tag, "_cnt"}, int'(step_cnt), m_cnt);
  endtask

  // Issue one start command. cut>0 interrupts at edge start+cut (abort, or reset held two
  // edges when use_rst). spur re-presents start and load one edge into the run.
  task automatic run_cmd(input bit d, input int n, input int dv, input int cut,
                         input bit use_rst, input bit spur, input string tag);
    int s, c, e, t, fin, normal;
    @(posedge clk); #1;
    start = 1'b1; dir = d; steps = CW'(n); div = DW'(dv);
    s = cyc + 1;
    c = (cut > 0) ? s + cut : 32'h7fff_ffff;
    if (n == 0) begin
      exp_q.push_back('{1, jc(m_idx), m_cnt, s});
      normal = s + 1;
    end else begin
      m_cnt = n;
      for (int i = 1; i <= n; i++) begin
        e = s + i * (dv + 1);
        if (e >= c) break;
        m_idx = step_idx(m_idx, d);
        m_cnt = n - i;
        exp_q.push_back('{0, jc(m_idx), m_cnt, e});
        if (i == n) exp_q.push_back('{1, jc(m_idx), 0, e});
      end
      normal = s + n * (dv + 1) + 1;
    end
    if (cut > 0 && use_rst) begin
      m_idx = 0;
      m_cnt = 0;
    end
    fin = (cut > 0 && c + 2 > normal) ? c + 2 : normal;
    do begin
      @(posedge clk); #1;
      t = cyc;
      start = 1'b0; load = 1'b0; abort = 1'b0;
      if (spur && n > 0 && t == s) begin
        start = 1'b1; dir = ~d; steps = CW'($urandom_range(1, 9)); div = DW'($urandom_range(0, 3));
        load = 1'b1; load_val = W'($urandom);
      end
      if (cut > 0) begin
        if (!use_rst && t == c - 1) abort = 1'b1;
        if (use_rst) rst = !(t == c - 1 || t == c);
      end
    end while (t < fin + 2);
    end_checks(tag);
  endtask

  task automatic do_load(input logic [W-1:0] v, input bit with_start, input string tag);
    int l, k;
    @(posedge clk); #1;
    load = 1'b1; load_val = v;
    if (with_start) begin
      start = 1'b1; dir = 1'b1; steps = CW'(5); div = '0;
    end
    l = cyc + 1;
    k = idx_of(v);
    if (k < 0) begin
      exp_q.push_back('{2, jc(m_idx), m_cnt, l});
    end else begin
      if (jc(m_idx) !== v) exp_q.push_back('{0, v, m_cnt, l});
      m_idx = k;
    end
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    end_checks(tag);
  endtask

  initial begin
    int n, dv, r, cut;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_cnt", int'(step_cnt), 0);
    rst = 1'b1;

    run_cmd(1'b1, 8, 0, 0, 1'b0, 1'b0, "fwd8");        // full forward lap
    run_cmd(1'b0, 3, 2, 0, 1'b0, 1'b0, "rev3_div2");   // reverse with period 3
    run_cmd(1'b1, 6, 1, 5, 1'b1, 1'b0, "rst_midrun");  // reset during RUN
    do_load(4'b0110, 1'b0, "load_bad");
    do_load(4'b0011, 1'b0, "load_ok");
    do_load(4'b1100, 1'b1, "load_start");
    run_cmd(1'b1, 5, 0, 3, 1'b0, 1'b0, "abort2");      // abort after two steps
    run_cmd(1'b1, 0, 0, 0, 1'b0, 1'b0, "steps0");
    run_cmd(1'b1, 4, 1, 0, 1'b0, 1'b1, "restart_run"); // start/load in RUN ignored
    run_cmd(1'b1, 9, 0, 0, 1'b0, 1'b0, "wrap");

    // Abort while idle must do nothing.
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    end_checks("abort_idle");

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load(W'($urandom), 1'($urandom_range(0, 1)), "rnd_load");
      end else begin
        n   = $urandom_range(0, 10);
        dv  = $urandom_range(0, 3);
        r   = $urandom_range(0, 9);
        cut = (r < 3) ? $urandom_range(1, n * (dv + 1) + 1) : 0;
        run_cmd(1'($urandom_range(0, 1)), n, dv, cut, r == 0, 1'($urandom_range(0, 1)),
                "rnd_cmd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
